// File: rtl/rx_pkt_deframer.sv
`default_nettype none
// ============================================================================
// Module      : rx_pkt_deframer
// Description : Locks onto A5/5A packet sync in the radio RX byte stream,
//               verifies the XOR checksum and unpacks 3-byte groups into
//               12-bit pixel pairs. Only verified packets are replayed from
//               the pixel buffer as an optional FraimSync pulse followed by
//               a burst of RxData/RxValid.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_pkt_deframer #(
    parameter int PAIRS_MAX = 32
) (
    input  logic        Cclk,
    input  logic        rst,
    input  logic [7:0]  RxByte,
    input  logic        RxByteValid,
    output logic        RxByteReady,
    output logic        FraimSync,
    output logic [11:0] RxData,
    output logic        RxValid,
    output logic [15:0] PktCnt,
    output logic [7:0]  ErrCnt
);

    localparam int c_NPIX = 2 * PAIRS_MAX;
    localparam int c_BW   = $clog2(3 * PAIRS_MAX + 1);
    localparam int c_PW   = $clog2(c_NPIX + 1);
    localparam int c_AW   = (c_NPIX > 1) ? $clog2(c_NPIX) : 1;

    localparam logic [7:0] c_SYNC0   = 8'hA5;
    localparam logic [7:0] c_SYNC1   = 8'h5A;
    localparam logic [7:0] c_LEN_MAX = 8'(PAIRS_MAX);

    localparam logic [2:0] c_ST_HUNT0    = 3'd0;
    localparam logic [2:0] c_ST_HUNT1    = 3'd1;
    localparam logic [2:0] c_ST_FLAGS    = 3'd2;
    localparam logic [2:0] c_ST_LEN      = 3'd3;
    localparam logic [2:0] c_ST_PAYLOAD  = 3'd4;
    localparam logic [2:0] c_ST_CHECK    = 3'd5;
    localparam logic [2:0] c_ST_SYNC_OUT = 3'd6;
    localparam logic [2:0] c_ST_DRAIN    = 3'd7;

    logic [2:0]      r_state;
    logic [7:0]      r_chk;
    logic            r_frame;
    logic [c_BW-1:0] r_bytes_left;
    logic [c_PW-1:0] r_npix;
    logic [c_PW-1:0] r_rd_idx;
    logic [c_AW-1:0] r_wr_idx;
    logic [1:0]      r_phase;
    logic [7:0]      r_hi;
    logic [3:0]      r_nib;
    logic            r_ready;
    logic            r_fsync;
    logic [11:0]     r_data;
    logic            r_valid;
    logic [15:0]     r_pkt;
    logic [7:0]      r_err;
    logic [11:0]     r_buf [0:c_NPIX-1];

    logic            w_xfer;
    logic [c_BW-1:0] w_len_bw;
    logic [c_BW-1:0] w_len3;
    logic [c_PW-1:0] w_len_pw;
    logic [c_PW-1:0] w_npix;
    logic            w_len_bad;
    logic [7:0]      w_chk_next;
    logic [7:0]      w_err_next;
    logic [c_AW-1:0] w_rd_addr;
    logic            w_buf_we;
    logic [11:0]     w_buf_wdata;

    assign w_xfer     = RxByteValid && r_ready;
    assign w_len_bw   = c_BW'(RxByte);
    assign w_len3     = (w_len_bw << 1) + w_len_bw;
    assign w_len_pw   = c_PW'(RxByte);
    assign w_npix     = w_len_pw << 1;
    assign w_len_bad  = (RxByte == 8'd0) || (RxByte > c_LEN_MAX);
    assign w_chk_next = r_chk ^ RxByte;
    assign w_err_next = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

    assign RxByteReady = r_ready;
    assign FraimSync   = r_fsync;
    assign RxData      = r_data;
    assign RxValid     = r_valid;
    assign PktCnt      = r_pkt;
    assign ErrCnt      = r_err;

    // Buffer write address/data: the first byte of a group is only held, the
    // second completes pixel A and the third completes pixel B.
    always_comb begin
        w_buf_we    = 1'b0;
        w_buf_wdata = {r_nib, RxByte};
        w_rd_addr   = '0;
        if (w_xfer && (r_state == c_ST_PAYLOAD) && (r_phase != 2'd0)) begin
            w_buf_we = 1'b1;
        end
        if (r_phase == 2'd1) begin
            w_buf_wdata = {r_hi, RxByte[7:4]};
        end
        if (r_state == c_ST_DRAIN) begin
            w_rd_addr = r_rd_idx[c_AW-1:0];
        end
    end

    // Pixel buffer; contents are don't-care until a packet has been written.
    always_ff @(posedge Cclk) begin
        if (w_buf_we) begin
            r_buf[r_wr_idx] <= w_buf_wdata;
        end
    end

    // Packet parser / drain sequencer with registered outputs.
    always_ff @(posedge Cclk) begin
        if (rst) begin
            r_state      <= c_ST_HUNT0;
            r_chk        <= '0;
            r_frame      <= 1'b0;
            r_bytes_left <= '0;
            r_npix       <= '0;
            r_rd_idx     <= '0;
            r_wr_idx     <= '0;
            r_phase      <= '0;
            r_hi         <= '0;
            r_nib        <= '0;
            r_ready      <= 1'b1;
            r_fsync      <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_pkt        <= '0;
            r_err        <= '0;
        end else begin
            r_fsync <= 1'b0;
            r_valid <= 1'b0;
            case (r_state)
                c_ST_HUNT0: begin
                    if (w_xfer && (RxByte == c_SYNC0)) begin
                        r_state <= c_ST_HUNT1;
                    end
                end
                c_ST_HUNT1: begin
                    if (w_xfer) begin
                        if (RxByte == c_SYNC1) begin
                            r_state <= c_ST_FLAGS;
                        end else if (RxByte != c_SYNC0) begin
                            r_state <= c_ST_HUNT0;
                        end
                    end
                end
                c_ST_FLAGS: begin
                    if (w_xfer) begin
                        r_frame <= RxByte[0];
                        r_chk   <= RxByte;
                        r_state <= c_ST_LEN;
                    end
                end
                c_ST_LEN: begin
                    if (w_xfer) begin
                        if (w_len_bad) begin
                            r_err   <= w_err_next;
                            r_state <= c_ST_HUNT0;
                        end else begin
                            r_chk        <= w_chk_next;
                            r_bytes_left <= w_len3;
                            r_npix       <= w_npix;
                            r_wr_idx     <= '0;
                            r_phase      <= '0;
                            r_state      <= c_ST_PAYLOAD;
                        end
                    end
                end
                c_ST_PAYLOAD: begin
                    if (w_xfer) begin
                        r_chk        <= w_chk_next;
                        r_bytes_left <= r_bytes_left - c_BW'(1);
                        case (r_phase)
                            2'd0: begin
                                r_hi    <= RxByte;
                                r_phase <= 2'd1;
                            end
                            2'd1: begin
                                r_nib    <= RxByte[3:0];
                                r_wr_idx <= r_wr_idx + c_AW'(1);
                                r_phase  <= 2'd2;
                            end
                            default: begin
                                r_wr_idx <= r_wr_idx + c_AW'(1);
                                r_phase  <= 2'd0;
                            end
                        endcase
                        if (r_bytes_left == c_BW'(1)) begin
                            r_state <= c_ST_CHECK;
                        end
                    end
                end
                c_ST_CHECK: begin
                    if (w_xfer) begin
                        if (RxByte != r_chk) begin
                            r_err   <= w_err_next;
                            r_state <= c_ST_HUNT0;
                        end else begin
                            r_pkt   <= r_pkt + 16'd1;
                            r_ready <= 1'b0;
                            if (r_frame) begin
                                r_fsync <= 1'b1;
                                r_state <= c_ST_SYNC_OUT;
                            end else begin
                                // Non-frame packets start streaming on the very next cycle.
                                r_valid  <= 1'b1;
                                r_data   <= r_buf[w_rd_addr];
                                r_rd_idx <= c_PW'(1);
                                r_state  <= c_ST_DRAIN;
                            end
                        end
                    end
                end
                c_ST_SYNC_OUT: begin
                    r_valid  <= 1'b1;
                    r_data   <= r_buf[w_rd_addr];
                    r_rd_idx <= c_PW'(1);
                    r_state  <= c_ST_DRAIN;
                end
                c_ST_DRAIN: begin
                    if (r_rd_idx == r_npix) begin
                        r_ready <= 1'b1;
                        r_state <= c_ST_HUNT0;
                    end else begin
                        r_valid  <= 1'b1;
                        r_data   <= r_buf[w_rd_addr];
                        r_rd_idx <= r_rd_idx + c_PW'(1);
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= c_ST_HUNT0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/rx_pkt_deframer.md
# rx_pkt_deframer

Upstream stage of the receive pixel memory. Takes the byte stream read out of the CC1200 RX FIFO, locks onto packet sync, checks each packet and unpacks its payload into 12-bit pixels. Only checksum-verified packets are released, as a FraimSync pulse plus a burst of RxData/RxValid that writes straight into the Y memory address counter.

## Interface
- PAIRS_MAX, 32: maximum pixel pairs per packet. The buffer holds 2*PAIRS_MAX 12-bit pixels.
- Cclk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- RxByte  in  8  byte from the radio FIFO reader.
- RxByteValid  in  1  RxByte is valid.
- RxByteReady  out  1  block accepts a byte. A transfer occurs on a Cclk edge where RxByteValid && RxByteReady.
- FraimSync  out  1  one-cycle pulse before the pixels of a frame-start packet.
- RxData  out  12  pixel data.
- RxValid  out  1  RxData is valid; one pixel per cycle.
- PktCnt  out  16  count of good packets; wraps.
- ErrCnt  out  8  count of dropped packets; saturates at 0xFF.

## Operation
- Packet format, in byte order:
  - SYNC0 = 0xA5, SYNC1 = 0x5A.
  - FLAGS: bit0 = frame start; bits 7:1 are ignored.
  - LEN = N pixel pairs.
  - 3N payload bytes.
  - CHK = XOR of FLAGS, LEN and all payload bytes.
- Unpacking: bytes b0 b1 b2 give pixel A = {b0, b1[7:4]} then pixel B = {b1[3:0], b2}. Pixels are written to the buffer in arrival order.
- States:
  - HUNT0: a 0xA5 byte moves to HUNT1.
  - HUNT1: 0x5A moves to FLAGS; 0xA5 stays in HUNT1; any other byte returns to HUNT0.
  - FLAGS: latch bit0, load checksum with the byte, move to LEN.
  - LEN: if N == 0 or N > PAIRS_MAX, drop the packet (ErrCnt++) and return to HUNT0. Otherwise latch N and move to PAYLOAD.
  - PAYLOAD: XOR each byte into the checksum and unpack it. Move to CHECK after byte 3N.
  - CHECK: on receiving CHK, a mismatch means ErrCnt++ and return to HUNT0. A match means PktCnt++, then go to SYNC_OUT if frame start, else DRAIN.
  - SYNC_OUT: one cycle, then DRAIN.
  - DRAIN: 2N cycles reading the buffer from index 0, then HUNT0.
- State advances only on byte transfers, except in SYNC_OUT and DRAIN.
- RxByteReady = 1 in every state except SYNC_OUT and DRAIN, where it is 0.
- A dropped packet produces no FraimSync and no RxValid.
- Byte and pixel counters are sized for 3*PAIRS_MAX and 2*PAIRS_MAX.
- Reset:
  - takes effect on the next edge from any state, including mid-DRAIN;
  - goes to HUNT0;
  - clears FraimSync, RxValid, RxData, PktCnt and ErrCnt;
  - sets RxByteReady = 1 after reset;
  - leaves buffer contents undefined, and they are never output without a fresh good packet.
- The buffer is a single-write-port, single-read-port array. Write and read never overlap, because ready is low during drain.

## Timing
- All outputs are registered.
- Let T be the edge that accepts CHK with a match.
  - Frame-start packet: FraimSync = 1 in cycle T+1 only; RxValid = 1 in cycles T+2 .. T+2N+1.
  - Otherwise: RxValid = 1 in cycles T+1 .. T+2N.
- RxValid is never high in the same cycle as FraimSync.
- RxByteReady is 0 from cycle T+1 through the last RxValid cycle, and returns to 1 in the cycle after it.
- PktCnt and ErrCnt update in the cycle after the deciding byte transfer.
- Bytes may arrive back-to-back or with arbitrary gaps of RxByteValid = 0. Gaps do not affect parsing.
- There is no timeout: a stalled packet waits indefinitely.

## Test plan
- Good frame-start packet: A5 5A 01 02 12 34 56 78 9A BC 2D.
  - FraimSync pulses once.
  - Then RxValid is high for 4 cycles with RxData = 0x123, 0x456, 0x789, 0xABC.
  - PktCnt = 1, ErrCnt = 0.
- Same packet with FLAGS = 00 and CHK = 2C: no FraimSync; the same 4 pixels appear starting the cycle after CHK.
- Same packet with CHK = 2E: no FraimSync or RxValid. ErrCnt = 1, and the block stays ready.
- Sync slip: 33 A5 A5 5A followed by the first packet's body. The packet is received correctly and 33 is ignored.
- LEN = 00, then LEN = 33 (with PAIRS_MAX = 32): each is dropped immediately with ErrCnt incrementing, and the following good packet decodes.
- Back-to-back good packets with RxByteValid held high:
  - no byte is accepted while RxByteReady = 0;
  - the second packet's pixels follow correctly.
- Reset mid-DRAIN: RxValid = 0 the cycle after reset, counters read 0, and a following good packet decodes normally.
- ErrCnt saturation: after 300 bad packets ErrCnt = 0xFF.
